// File: rtl/rf_wb_queue.sv
// Register-file writeback queue: 4-entry FIFO that retires one write per cycle.
// Optional same-cycle empty-queue bypass enabled by defining WBQ_BYPASS_EN.
module rf_wb_queue (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_addr,
  input  logic [31:0] in_data,
  output logic        RFWr,
  output logic [4:0]  A3,
  output logic [31:0] WD,
  output logic [2:0]  q_count,
  input  logic [4:0]  chk_addr1,
  input  logic [4:0]  chk_addr2,
  output logic        pend1,
  output logic        pend2
);

  localparam int unsigned Depth = 4;

  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic [3:0]  valid_q, valid_d;
  logic [4:0]  addr_q [Depth];
  logic [31:0] data_q [Depth];

  logic handshake;
  logic bypass;
  logic push;
  logic pop;
  logic not_empty;

  assign not_empty = (count_q != 3'd0);
  assign in_ready  = !rst && (count_q < 3'd4);
  assign handshake = in_valid && in_ready;

`ifdef WBQ_BYPASS_EN
  // Bypassed requests go straight to the RF port and are never stored.
  assign bypass = handshake && !not_empty && (in_addr != 5'd0);
`else
  assign bypass = 1'b0;
`endif

  // Writes to register 0 complete the handshake but are dropped.
  assign push = handshake && (in_addr != 5'd0) && !bypass;
  assign pop  = !rst && not_empty;

  always_comb begin
    RFWr = 1'b0;
    A3   = 5'd0;
    WD   = 32'd0;
    if (pop) begin
      RFWr = 1'b1;
      A3   = addr_q[rd_ptr_q];
      WD   = data_q[rd_ptr_q];
    end else if (bypass) begin
      RFWr = 1'b1;
      A3   = in_addr;
      WD   = in_data;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    count_d  = count_q;
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 2'd1;
    end
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + 2'd1;
    end
    count_d = count_q + {2'b00, push} - {2'b00, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      valid_q  <= 4'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Payload is qualified by valid bits, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= in_addr;
      data_q[wr_ptr_q] <= in_data;
    end
  end

  // Hazard check sees stored entries only, never the incoming request.
  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      if (valid_q[i] && (addr_q[i] == chk_addr1) && (chk_addr1 != 5'd0)) pend1 = 1'b1;
      if (valid_q[i] && (addr_q[i] == chk_addr2) && (chk_addr2 != 5'd0)) pend2 = 1'b1;
    end
  end

  assign q_count = count_q;

  property p_count_bound;
    @(posedge clk) disable iff (rst) count_q <= 3'd4;
  endproperty
  a_count_bound: assert property (p_count_bound);

  property p_no_push_when_full;
    @(posedge clk) disable iff (rst) (count_q == 3'd4) |-> !push;
  endproperty
  a_no_push_when_full: assert property (p_no_push_when_full);

endmodule
